// File: rtl/coin_pkg.sv
// coin_pkg: shared constants and types for the coin acceptor front end.
package coin_pkg;

    // Coin denominations; the enum value is the channel index of that coin.
    typedef enum logic [1:0] {
        NICKEL  = 2'd0,
        DIME    = 2'd1,
        QUARTER = 2'd2
    } coin_denom_e;

    localparam int NUM_COINS_DEF = 3;
    localparam int VALUE_W_DEF   = 5;
    localparam int CREDIT_W_DEF  = 8;

    // Entry i is the value of channel i (nickel on channel 0, quarter on channel 2).
    localparam logic [NUM_COINS_DEF-1:0][VALUE_W_DEF-1:0] COIN_VALUES_DEF = {5'd25, 5'd10, 5'd5};

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: one coin channel -- 2-flop synchroniser, debounce counter,
// stable state and its one-cycle-delayed copy; emits a single-cycle rise.
module coin_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic coin_i,
    output logic stable_o,
    output logic rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic             r_stable_prev;
    logic [CNT_W-1:0] r_cnt;

    // Bring the raw sensor line into the clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= coin_i;
            r_sync <= r_meta;
        end
    end

    // Flip the stable state only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delayed stable state for rising-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stable_prev <= 1'b0;
        end else begin
            r_stable_prev <= r_stable;
        end
    end

    assign stable_o = r_stable;
    assign rise_o   = r_stable & ~r_stable_prev;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: per-channel debounce, single-coin event resolution with
// conflict detection, registered event outputs. Optional credit accumulator
// is built when the macro COIN_ACC_CREDIT_EN is defined.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int NUM_COINS       = NUM_COINS_DEF,
    parameter int VALUE_W         = VALUE_W_DEF,
    parameter logic [NUM_COINS-1:0][VALUE_W-1:0] COIN_VALUES = COIN_VALUES_DEF,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CREDIT_W        = CREDIT_W_DEF,
    localparam int IDX_W          = (NUM_COINS > 1) ? $clog2(NUM_COINS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_COINS-1:0] coin_i,
    output logic                 pressed_o,
    output logic                 coin_valid_o,
    output logic [VALUE_W-1:0]   coin_value_o,
    output logic [IDX_W-1:0]     coin_idx_o,
    output logic                 conflict_o
`ifdef COIN_ACC_CREDIT_EN
    ,
    input  logic                 credit_clr_i,
    output logic [CREDIT_W-1:0]  credit_o,
    output logic                 credit_sat_o
`endif
);

    logic [NUM_COINS-1:0] w_rise;
    logic [NUM_COINS-1:0] w_stable;
    logic                 w_one;
    logic                 w_multi;
    logic [IDX_W-1:0]     w_idx;

    logic                 r_pressed;
    logic                 r_coin_valid;
    logic [VALUE_W-1:0]   r_coin_value;
    logic [IDX_W-1:0]     r_coin_idx;
    logic                 r_conflict;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COINS; gi++) begin : g_chan
            coin_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk_i   (clk_i),
                .rst_i   (rst_i),
                .coin_i  (coin_i[gi]),
                .stable_o(w_stable[gi]),
                .rise_o  (w_rise[gi])
            );
        end
    endgenerate

    // Classify the rise vector: none, exactly one (with its index), or several.
    always_comb begin
        w_one   = 1'b0;
        w_multi = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (w_rise[i]) begin
                if (w_one) begin
                    w_multi = 1'b1;
                end
                w_one = 1'b1;
                w_idx = IDX_W'(i);
            end
        end
    end

    // Register the resolved event; value and index are zero unless a single coin is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pressed    <= 1'b0;
            r_coin_valid <= 1'b0;
            r_coin_value <= '0;
            r_coin_idx   <= '0;
            r_conflict   <= 1'b0;
        end else begin
            r_pressed    <= |w_stable;
            r_coin_valid <= w_one & ~w_multi;
            r_conflict   <= w_multi;
            if (w_one && !w_multi) begin
                r_coin_value <= COIN_VALUES[w_idx];
                r_coin_idx   <= w_idx;
            end else begin
                r_coin_value <= '0;
                r_coin_idx   <= '0;
            end
        end
    end

    assign pressed_o    = r_pressed;
    assign coin_valid_o = r_coin_valid;
    assign coin_value_o = r_coin_value;
    assign coin_idx_o   = r_coin_idx;
    assign conflict_o   = r_conflict;

`ifdef COIN_ACC_CREDIT_EN
    localparam int SUM_W = CREDIT_W + 1;

    logic [CREDIT_W-1:0] r_credit;
    logic                r_credit_sat;
    logic [CREDIT_W-1:0] w_credit_base;
    logic [SUM_W-1:0]    w_credit_sum;
    logic                w_credit_ovf;

    // A clear restarts from zero, so a coin arriving with the clear is still counted.
    always_comb begin
        w_credit_base = credit_clr_i ? '0 : r_credit;
        w_credit_sum  = {1'b0, w_credit_base} + (r_coin_valid ? SUM_W'(r_coin_value) : '0);
        w_credit_ovf  = w_credit_sum[CREDIT_W];
    end

    // Saturating accumulate with a sticky saturation flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_credit     <= '0;
            r_credit_sat <= 1'b0;
        end else if (credit_clr_i || r_coin_valid) begin
            r_credit     <= w_credit_ovf ? '1 : w_credit_sum[CREDIT_W-1:0];
            r_credit_sat <= (credit_clr_i ? 1'b0 : r_credit_sat) | w_credit_ovf;
        end
    end

    assign credit_o     = r_credit;
    assign credit_sat_o = r_credit_sat;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed scenarios plus randomized stimulus, all checked
// every cycle against a window-based behavioural model of the acceptor.
module tb_coin_acceptor;
    import coin_pkg::*;

    localparam int NC = 3;
    localparam int VW = 5;
    localparam int IW = 2;
    localparam int DB = 4;
`ifdef COIN_ACC_CREDIT_EN
    localparam int CW = 5;
`else
    localparam int CW = 8;
`endif
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NC-1:0] coin = '0;
    logic          pressed;
    logic          valid;
    logic [VW-1:0] value;
    logic [IW-1:0] idx;
    logic          conflict;
`ifdef COIN_ACC_CREDIT_EN
    logic          clr = 1'b0;
    logic [CW-1:0] credit;
    logic          sat;
`endif

    coin_acceptor #(
        .NUM_COINS      (NC),
        .VALUE_W        (VW),
        .COIN_VALUES    ({5'd25, 5'd10, 5'd5}),
        .DEBOUNCE_CYCLES(DB),
        .CREDIT_W       (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .coin_i      (coin),
        .pressed_o   (pressed),
        .coin_valid_o(valid),
        .coin_value_o(value),
        .coin_idx_o  (idx),
        .conflict_o  (conflict)
`ifdef COIN_ACC_CREDIT_EN
        ,
        .credit_clr_i(clr),
        .credit_o    (credit),
        .credit_sat_o(sat)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Channel values straight from the denomination table.
    int            coin_val [NC] = '{5, 10, 25};
    logic [NC-1:0] hist [$];      // raw input sampled at each edge since reset
    logic [NC-1:0] m_stable = '0;
    logic [NC-1:0] m_rise   = '0;
    bit            e_valid = 0, e_conflict = 0, e_pressed = 0, e_sat = 0;
    int            e_value = 0, e_idx = 0, e_credit = 0;
    int            cyc = 0;

    // The debounced state flips once the last DB synchronised samples (raw input
    // delayed two edges) all disagree with it.
    task automatic model_step();
        int n, k, cnt, base, sum;
        bit flip, smp;
        logic [NC-1:0] nst;
        if (rst) begin
            hist.delete();
            m_stable = '0; m_rise = '0;
            e_valid = 0; e_conflict = 0; e_pressed = 0; e_value = 0; e_idx = 0;
            e_credit = 0; e_sat = 0;
            return;
        end
`ifdef COIN_ACC_CREDIT_EN
        if (clr || e_valid) begin
            base = clr ? 0 : e_credit;
            sum  = base + (e_valid ? e_value : 0);
            if (sum > MAXC) begin
                e_credit = MAXC;
                e_sat    = 1;
            end else begin
                e_credit = sum;
                if (clr) e_sat = 0;
            end
        end
`endif
        cnt        = $countones(m_rise);
        e_valid    = (cnt == 1);
        e_conflict = (cnt > 1);
        e_pressed  = |m_stable;
        e_value    = 0;
        e_idx      = 0;
        if (e_valid) begin
            for (int c = 0; c < NC; c++) begin
                if (m_rise[c]) begin
                    e_idx   = c;
                    e_value = coin_val[c];
                end
            end
        end
        hist.push_back(coin);
        n = hist.size() - 1;
        for (int c = 0; c < NC; c++) begin
            flip = 1;
            for (int j = 0; j < DB; j++) begin
                k   = n - 2 - j;
                smp = (k < 0) ? 1'b0 : hist[k][c];
                if (smp == m_stable[c]) flip = 0;
            end
            nst[c] = flip ? ~m_stable[c] : m_stable[c];
        end
        m_rise   = nst & ~m_stable;
        m_stable = nst;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
    end

    // ---------------- per-cycle comparison and event log ----------------
    int n_valid = 0, n_conf = 0;
    int last_value = -1, last_idx = -1, last_vcyc = 0, prev_vcyc = 0;
    bit last_pressed = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(valid), 0);
            chk("rst_conflict", 32'(conflict), 0);
            chk("rst_value", 32'(value), 0);
            chk("rst_idx", 32'(idx), 0);
            chk("rst_pressed", 32'(pressed), 0);
`ifdef COIN_ACC_CREDIT_EN
            chk("rst_credit", 32'(credit), 0);
            chk("rst_sat", 32'(sat), 0);
`endif
        end else begin
            chk("valid", 32'(valid), 32'(e_valid));
            chk("conflict", 32'(conflict), 32'(e_conflict));
            chk("value", 32'(value), 32'(e_value));
            chk("idx", 32'(idx), 32'(e_idx));
            chk("pressed", 32'(pressed), 32'(e_pressed));
`ifdef COIN_ACC_CREDIT_EN
            chk("credit", 32'(credit), 32'(e_credit));
            chk("credit_sat", 32'(sat), 32'(e_sat));
`endif
        end
        if (valid) begin
            n_valid++;
            last_value   = int'(value);
            last_idx     = int'(idx);
            last_pressed = pressed;
            prev_vcyc    = last_vcyc;
            last_vcyc    = cyc;
            $display("[%0d] coin idx=%0d value=%0d", cyc, idx, value);
        end
        if (conflict) begin
            n_conf++;
            $display("[%0d] conflict", cyc);
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 2 time units after a rising edge.
    task automatic hold(input logic [NC-1:0] c, input int n);
        coin = c;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

`ifdef COIN_ACC_CREDIT_EN
    task automatic clr_pulse();
        clr = 1'b1;
        @(posedge clk);
        #2;
        clr = 1'b0;
    endtask
`endif

    int v0, c0, edge0, k;

    initial begin
        @(posedge clk); #2;
        hold('0, 3);
        rst = 1'b0;
        hold('0, 3);

        // Single dime: latency, value, index, pressed.
        v0 = n_valid; c0 = n_conf; edge0 = cyc + 1;
        hold(3'b010, 10);
        hold('0, 10);
        chk("dime_count", 32'(n_valid - v0), 1);
        chk("dime_conflicts", 32'(n_conf - c0), 0);
        chk("dime_value", 32'(last_value), 10);
        chk("dime_idx", 32'(last_idx), 1);
        chk("dime_latency", 32'(last_vcyc - edge0), 6);
        chk("dime_pressed", 32'(last_pressed), 1);

        // Glitch of 3 cycles is filtered.
        v0 = n_valid; c0 = n_conf;
        hold(3'b001, 3);
        hold('0, 10);
        chk("glitch_count", 32'(n_valid - v0), 0);
        chk("glitch_conflicts", 32'(n_conf - c0), 0);

        // Simultaneous nickel and quarter: one conflict, no coin.
        v0 = n_valid; c0 = n_conf;
        hold(3'b101, 10);
        hold('0, 10);
        chk("conf_count", 32'(n_conf - c0), 1);
        chk("conf_valid", 32'(n_valid - v0), 0);

        // Staggered quarter then nickel.
`ifdef COIN_ACC_CREDIT_EN
        clr_pulse();
`endif
        v0 = n_valid;
        hold(3'b100, 2);
        hold(3'b101, 10);
        hold('0, 10);
        chk("stag_count", 32'(n_valid - v0), 2);
        chk("stag_gap", 32'(last_vcyc - prev_vcyc), 2);
        chk("stag_last_value", 32'(last_value), 5);
`ifdef COIN_ACC_CREDIT_EN
        chk("stag_credit", 32'(credit), 30);

        // Saturation, then clear coinciding with a dime.
        clr_pulse();
        hold(3'b100, 8);
        hold('0, 8);
        hold(3'b100, 8);
        hold('0, 8);
        chk("sat_credit", 32'(credit), 31);
        chk("sat_flag", 32'(sat), 1);
        coin = 3'b010;
        for (k = 0; k < 20 && !valid; k++) begin
            @(posedge clk); #2;
        end
        chk("clr_dime_seen", 32'(valid), 1);
        clr = 1'b1;
        @(posedge clk); #2;
        clr = 1'b0;
        @(posedge clk); #2;
        chk("clr_dime_credit", 32'(credit), 10);
        chk("clr_dime_sat", 32'(sat), 0);
        hold('0, 10);
`endif

        // Reset two cycles into a debounce: nothing reported.
        v0 = n_valid; c0 = n_conf;
        hold(3'b010, 2);
        coin = '0;
        rst  = 1'b1;
        #1;
        chk("midrst_valid", 32'(valid), 0);
        chk("midrst_pressed", 32'(pressed), 0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b0;
        hold('0, 12);
        chk("midrst_count", 32'(n_valid - v0), 0);
        chk("midrst_conflicts", 32'(n_conf - c0), 0);

        // Line already high when reset is released is reported once.
        rst = 1'b1;
        hold(3'b100, 2);
        v0 = n_valid;
        rst = 1'b0;
        hold(3'b100, 10);
        hold('0, 10);
        chk("held_count", 32'(n_valid - v0), 1);
        chk("held_value", 32'(last_value), 25);

        // Randomized slowly-toggling lines, checked each cycle by the model.
        for (int t = 0; t < 600; t++) begin
            logic [NC-1:0] nc;
            nc = coin;
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 7) == 0) nc[c] = ~nc[c];
            end
`ifdef COIN_ACC_CREDIT_EN
            clr = ($urandom_range(0, 15) == 0);
`endif
            hold(nc, 1);
        end
`ifdef COIN_ACC_CREDIT_EN
        clr = 1'b0;
`endif
        hold('0, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
